apb_master_fsm: RTL and testbench

Registered APB master stage that converts single-beat commands from the bridge core into APB transfers and returns read data and status. It sits directly upstream of the APB bus, driving psel, penable, pwrite, paddr and pwdata toward the crypto peripheral. It is the component the APB channel protocol checker watches. One command is in flight at a time, with an optional wait-state timeout.

---
 rtl/apb_master_pkg.sv | 21 ++
 rtl/apb_timeout_cnt.sv | 29 ++
 rtl/apb_master_fsm.sv | 143 ++++++++++++++
 tb/tb_apb_master_fsm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types for the APB master stage: FSM state encoding, default bus widths
// and the packed command record held in the capture register.
package apb_master_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait-state counter for the APB master. It flags expiry when
// LIMIT consecutive wait cycles would be exceeded by the current cycle.
module apb_timeout_cnt #(
  parameter int LIMIT = 256,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_reg;

  // Expiry is qualified by enable so a pready arriving on the last cycle wins.
  assign expired = enable && (cnt_reg == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_fsm.sv
// Single-outstanding APB master: command in, APB transfer out, response back.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_fsm
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_mst_state_e    state_reg, state_next;
  apb_cmd_t          cmd_reg, cmd_next;
  logic              cmd_ready_reg, cmd_ready_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              timeout_hit;
  logic              accept;

  // cmd_ready is a flop so it stays low throughout reset and on the first
  // cycle after release, instead of being decoded from the IDLE state.
  assign accept = (state_reg == IDLE) && cmd_ready_reg && cmd_valid;

`ifdef APB_TIMEOUT_EN
  logic rsp_err_reg;

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_reg == SETUP),
    .enable  ((state_reg == ACCESS) && !pready),
    .expired (timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_reg <= 1'b0;
    end else if ((state_reg == ACCESS) && (pready || timeout_hit)) begin
      rsp_err_reg <= !pready;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_reg)
      SETUP:   psel = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready_next = (state_next == IDLE);

    cmd_next = cmd_reg;
    if (accept) begin
      cmd_next.write = cmd_write;
      cmd_next.addr  = APB_ADDR_W'(cmd_addr);
      cmd_next.wdata = APB_DATA_W'(cmd_wdata);
    end

    rsp_rdata_next = rsp_rdata_reg;
    if (state_reg == ACCESS) begin
      if (pready) begin
        rsp_rdata_next = cmd_reg.write ? '0 : prdata;
      end else if (timeout_hit) begin
        rsp_rdata_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_reg <= 1'b0;
      cmd_reg       <= '0;
      rsp_rdata_reg <= '0;
    end else begin
      cmd_ready_reg <= cmd_ready_next;
      cmd_reg       <= cmd_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign pwrite    = cmd_reg.write;
  assign paddr     = ADDR_W'(cmd_reg.addr);
  assign pwdata    = DATA_W'(cmd_reg.wdata);

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: write, waited read, backpressure,
// back-to-back commands, mid-transfer reset and (with APB_TIMEOUT_EN) timeout.
module tb_apb_master_fsm;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_master_fsm #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic s, input logic e, input logic v);
    check({tag, ".psel"}, 64'(psel), 64'(s));
    check({tag, ".penable"}, 64'(penable), 64'(e));
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(v));
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0;

    // Reset values
    #2;
    check("rst.cmd_ready", 64'(cmd_ready), 64'd0);
    check_bus("rst", 1'b0, 1'b0, 1'b0);
    check("rst.rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst.rsp_err", 64'(rsp_err), 64'd0);
    check("rst.pwrite", 64'(pwrite), 64'd0);
    check("rst.paddr", 64'(paddr), 64'd0);
    check("rst.pwdata", 64'(pwdata), 64'd0);
    tick(); tick();
    check("rst_hold.cmd_ready", 64'(cmd_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle.cmd_ready", 64'(cmd_ready), 64'd1);
    $display("reset: cmd_ready=%0b psel=%0b rsp_valid=%0b", cmd_ready, psel, rsp_valid);

    // Zero-wait write 0x10 <- 0xDEADBEEF (pready already high in SETUP, ignored)
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF;
    pready = 1'b1; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check_bus("wr.T1", 1'b1, 1'b0, 1'b0);
    check("wr.T1.cmd_ready", 64'(cmd_ready), 64'd0);
    check("wr.T1.paddr", 64'(paddr), 64'h10);
    check("wr.T1.pwrite", 64'(pwrite), 64'd1);
    check("wr.T1.pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    tick();
    check_bus("wr.T2", 1'b1, 1'b1, 1'b0);
    check("wr.T2.pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    tick();
    check_bus("wr.T3", 1'b0, 1'b0, 1'b1);
    check("wr.T3.rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("wr.T3.rsp_err", 64'(rsp_err), 64'd0);
    check("wr.T3.pwdata_kept", 64'(pwdata), 64'hDEAD_BEEF);
    $display("write: addr=%0h data=%0h rsp_valid=%0b rdata=%0h", paddr, pwdata, rsp_valid, rsp_rdata);
    tick();
    check("wr.T4.rsp_valid", 64'(rsp_valid), 64'd0);
    check("wr.T4.cmd_ready", 64'(cmd_ready), 64'd1);

    // Read 0x20 with 3 wait states, then 5 cycles of response backpressure
    pready = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    tick();
    check_bus("rd.setup", 1'b1, 1'b0, 1'b0);
    check("rd.setup.pwrite", 64'(pwrite), 64'd0);
    // Next command offered immediately and held: must not be taken early
    cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hA5A5_A5A5;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd.acc%0d.penable", i), 64'(penable), 64'd1);
      check($sformatf("rd.acc%0d.paddr", i), 64'(paddr), 64'h20);
      check($sformatf("rd.acc%0d.rsp_valid", i), 64'(rsp_valid), 64'd0);
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h1234_5678;
      end
      tick();
    end
    pready = 1'b0; prdata = 32'hFFFF_FFFF;
    check_bus("rd.resp", 1'b0, 1'b0, 1'b1);
    check("rd.resp.rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
    $display("read: addr=20 rdata=%0h err=%0b", rsp_rdata, rsp_err);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d.rsp_valid", i), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d.rsp_rdata", i), 64'(rsp_rdata), 64'h1234_5678);
      check($sformatf("bp%0d.cmd_ready", i), 64'(cmd_ready), 64'd0);
      check($sformatf("bp%0d.paddr", i), 64'(paddr), 64'h20);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_bus("b2b.gap", 1'b0, 1'b0, 1'b0);
    check("b2b.gap.cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; pready = 1'b1;
    check_bus("b2b.setup", 1'b1, 1'b0, 1'b0);
    check("b2b.setup.paddr", 64'(paddr), 64'h30);
    check("b2b.setup.pwdata", 64'(pwdata), 64'hA5A5_A5A5);
    tick();
    check_bus("b2b.access", 1'b1, 1'b1, 1'b0);
    tick();
    check_bus("b2b.resp", 1'b0, 1'b0, 1'b1);
    check("b2b.resp.rsp_rdata", 64'(rsp_rdata), 64'd0);
    $display("b2b: addr=%0h data=%0h rsp_valid=%0b", paddr, pwdata, rsp_valid);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; pready = 1'b0;
    check("b2b.done.rsp_valid", 64'(rsp_valid), 64'd0);

    // Reset asserted during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mrst.pre.penable", 64'(penable), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bus("mrst.async", 1'b0, 1'b0, 1'b0);
    check("mrst.async.cmd_ready", 64'(cmd_ready), 64'd0);
    check("mrst.async.paddr", 64'(paddr), 64'd0);
    tick();
    rst_n = 1'b1; pready = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bus($sformatf("mrst.post%0d", i), 1'b0, 1'b0, 1'b0);
    end
    check("mrst.post.cmd_ready", 64'(cmd_ready), 64'd1);
    $display("midreset: psel=%0b rsp_valid=%0b cmd_ready=%0b", psel, rsp_valid, cmd_ready);
    pready = 1'b0; rsp_ready = 1'b0;

`ifdef APB_TIMEOUT_EN
    // Timeout abort after 8 ACCESS cycles
    prdata = 32'hCAFE_F00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("to.acc%0d.penable", i), 64'(penable), 64'd1);
      tick();
    end
    check_bus("to.resp", 1'b0, 1'b0, 1'b1);
    check("to.resp.rsp_err", 64'(rsp_err), 64'd1);
    check("to.resp.rsp_rdata", 64'(rsp_rdata), 64'd0);
    $display("timeout: rsp_err=%0b rdata=%0h", rsp_err, rsp_rdata);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to.idle.rsp_valid", 64'(rsp_valid), 64'd0);
    check("to.idle.cmd_ready", 64'(cmd_ready), 64'd1);

    // pready on the final allowed cycle wins over the timeout
    cmd_valid = 1'b1; cmd_addr = 32'h60;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tw.acc%0d.penable", i), 64'(penable), 64'd1);
      if (i == 7) pready = 1'b1;
      tick();
    end
    pready = 1'b0;
    check_bus("tw.resp", 1'b0, 1'b0, 1'b1);
    check("tw.resp.rsp_err", 64'(rsp_err), 64'd0);
    check("tw.resp.rsp_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
    $display("timeout_race: rsp_err=%0b rdata=%0h", rsp_err, rsp_rdata);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
